// File: rtl/channel_capture_scheduler_pkg.sv
// rtl/channel_capture_scheduler_pkg.sv - shared types, sizes and scan helper for the capture scheduler
package capture_sched_pkg;

    localparam int NUM_CHANNELS = 7;
    localparam int CH_W         = 3;
    localparam int SAMPLE_DEPTH = 10;
    localparam int IDX_W        = 4;
    localparam int DIV_W        = 24;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        CAPTURE   = 2'd2,
        READOUT   = 2'd3
    } sched_state_e;

    // Lowest set bit of mask at or above position from; -1 when there is none.
    function automatic int next_set_bit(input logic [31:0] mask, input int from);
        int result;
        result = -1;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && i >= from) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/channel_capture_scheduler_if.sv
// rtl/channel_capture_scheduler_if.sv - control, capture-strobe and readout signals of the scheduler
interface channel_capture_scheduler_if;
    import capture_sched_pkg::*;

    logic                    enable;
    logic [DIV_W-1:0]        div_cfg;
    logic [NUM_CHANNELS-1:0] ch_mask;
    logic                    cap_wr_en;
    logic [CH_W-1:0]         cap_ch;
    logic                    frame_done;
    logic                    overrun;
    logic                    rd_req;
    logic [CH_W-1:0]         rd_ch;
    logic                    rd_busy;
    logic                    rd_valid;
    logic [CH_W-1:0]         rd_ch_sel;
    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_done;

    modport master (
        output enable, div_cfg, ch_mask, rd_req, rd_ch,
        input  cap_wr_en, cap_ch, frame_done, overrun,
               rd_busy, rd_valid, rd_ch_sel, rd_idx, rd_done
    );

    modport slave (
        input  enable, div_cfg, ch_mask, rd_req, rd_ch,
        output cap_wr_en, cap_ch, frame_done, overrun,
               rd_busy, rd_valid, rd_ch_sel, rd_idx, rd_done
    );

endinterface

// File: rtl/channel_capture_scheduler_divider.sv
// rtl/channel_capture_scheduler_divider.sv - sample-rate tick generator, period div_cfg+1 cycles
module sample_rate_divider
    import capture_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Comparing with >= lets a shrunk div_cfg pull an overshot count back to 0.
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (!enable || cnt_q >= div_cfg) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == div_cfg);

endmodule

// File: rtl/channel_capture_scheduler.sv
// rtl/channel_capture_scheduler.sv - round-robin capture strobes per tick plus between-frame buffer readout
module channel_capture_scheduler
    import capture_sched_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    channel_capture_scheduler_if.slave  bus
);

    sched_state_e            state_q, state_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic                    cap_wr_en_q, cap_wr_en_d;
    logic [CH_W-1:0]         cap_ch_q, cap_ch_d;
    logic                    frame_done_q, frame_done_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [CH_W-1:0]         rd_ch_sel_q, rd_ch_sel_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic                    rd_done_q, rd_done_d;
    logic                    tick;
    logic                    start_frame;
    int                      first_ch, second_ch, next_ch, after_next_ch;

    sample_rate_divider u_divider (
        .clk     (clk),
        .reset   (reset),
        .enable  (bus.enable),
        .div_cfg (bus.div_cfg),
        .tick    (tick)
    );

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        mask_d        = mask_q;
        cap_wr_en_d   = 1'b0;
        cap_ch_d      = '0;
        frame_done_d  = 1'b0;
        rd_valid_d    = 1'b0;
        rd_ch_sel_d   = '0;
        rd_idx_d      = '0;
        rd_done_d     = 1'b0;
        start_frame   = 1'b0;
        first_ch      = next_set_bit(32'(bus.ch_mask), 0);
        second_ch     = next_set_bit(32'(bus.ch_mask), first_ch + 1);
        next_ch       = next_set_bit(32'(mask_q), int'(cap_ch_q) + 1);
        after_next_ch = next_set_bit(32'(mask_q), next_ch + 1);

        unique case (state_q)
            IDLE: state_d = WAIT_TICK;
            WAIT_TICK: begin
                if (tick || pending_q) begin
                    start_frame = 1'b1;
                end else if (bus.rd_req && int'(bus.rd_ch) < NUM_CHANNELS) begin
                    state_d     = READOUT;
                    rd_valid_d  = 1'b1;
                    rd_ch_sel_d = bus.rd_ch;
                    rd_done_d   = (SAMPLE_DEPTH == 1);
                end
            end
            CAPTURE: begin
                if (frame_done_q) begin
                    start_frame = pending_q;
                    state_d     = WAIT_TICK;
                end else begin
                    cap_wr_en_d  = 1'b1;
                    cap_ch_d     = CH_W'(next_ch);
                    frame_done_d = (after_next_ch < 0);
                end
            end
            READOUT: begin
                if (rd_done_q) begin
                    start_frame = pending_q;
                    state_d     = WAIT_TICK;
                end else begin
                    rd_valid_d  = 1'b1;
                    rd_ch_sel_d = rd_ch_sel_q;
                    rd_idx_d    = rd_idx_q + IDX_W'(1);
                    rd_done_d   = (rd_idx_q == IDX_W'(SAMPLE_DEPTH - 2));
                end
            end
        endcase

        // A tick landing on the cycle that consumes pending becomes the new pending.
        if (start_frame) begin
            pending_d = pending_q && tick;
            mask_d    = bus.ch_mask;
            state_d   = WAIT_TICK;
            if (first_ch >= 0) begin
                state_d      = CAPTURE;
                cap_wr_en_d  = 1'b1;
                cap_ch_d     = CH_W'(first_ch);
                frame_done_d = (second_ch < 0);
            end
        end else if (tick) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (!bus.enable) begin
            state_d      = IDLE;
            pending_d    = 1'b0;
            overrun_d    = 1'b0;
            mask_d       = '0;
            cap_wr_en_d  = 1'b0;
            cap_ch_d     = '0;
            frame_done_d = 1'b0;
            rd_valid_d   = 1'b0;
            rd_ch_sel_d  = '0;
            rd_idx_d     = '0;
            rd_done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            mask_q       <= '0;
            cap_wr_en_q  <= 1'b0;
            cap_ch_q     <= '0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_ch_sel_q  <= '0;
            rd_idx_q     <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            mask_q       <= mask_d;
            cap_wr_en_q  <= cap_wr_en_d;
            cap_ch_q     <= cap_ch_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_ch_sel_q  <= rd_ch_sel_d;
            rd_idx_q     <= rd_idx_d;
            rd_done_q    <= rd_done_d;
        end
    end

    assign bus.cap_wr_en  = cap_wr_en_q;
    assign bus.cap_ch     = cap_ch_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign bus.rd_busy    = rd_valid_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_ch_sel  = rd_ch_sel_q;
    assign bus.rd_idx     = rd_idx_q;
    assign bus.rd_done    = rd_done_q;

endmodule

// File: tb/tb_channel_capture_scheduler.sv
// tb/tb_channel_capture_scheduler.sv - directed checks of capture scheduling, readout, pending and overrun
module tb_channel_capture_scheduler;
    import capture_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    channel_capture_scheduler_if bus_if ();

    channel_capture_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic exp_cap(input string tag, input logic en, input int ch, input logic fd);
        check({tag, " cap_wr_en"}, 32'(bus_if.cap_wr_en), 32'(en));
        if (en) check({tag, " cap_ch"}, 32'(bus_if.cap_ch), 32'(ch));
        check({tag, " frame_done"}, 32'(bus_if.frame_done), 32'(fd));
    endtask

    task automatic exp_rd(input string tag, input logic vld, input int ch, input int idx, input logic done);
        check({tag, " rd_valid"}, 32'(bus_if.rd_valid), 32'(vld));
        check({tag, " rd_busy"}, 32'(bus_if.rd_busy), 32'(vld));
        check({tag, " rd_done"}, 32'(bus_if.rd_done), 32'(done));
        if (vld) begin
            check({tag, " rd_ch_sel"}, 32'(bus_if.rd_ch_sel), 32'(ch));
            check({tag, " rd_idx"}, 32'(bus_if.rd_idx), 32'(idx));
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drop enable for one edge so the next test starts from IDLE with a zeroed divider.
    task automatic restart();
        bus_if.enable = 1'b0;
        bus_if.rd_req = 1'b0;
        step();
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.enable  = 1'b0;
        bus_if.div_cfg = '0;
        bus_if.ch_mask = '0;
        bus_if.rd_req  = 1'b0;
        bus_if.rd_ch   = '0;
        repeat (3) step();
        check("reset cap_wr_en", 32'(bus_if.cap_wr_en), 0);
        check("reset cap_ch", 32'(bus_if.cap_ch), 0);
        check("reset frame_done", 32'(bus_if.frame_done), 0);
        check("reset overrun", 32'(bus_if.overrun), 0);
        check("reset rd_valid", 32'(bus_if.rd_valid), 0);
        check("reset rd_busy", 32'(bus_if.rd_busy), 0);
        check("reset rd_ch_sel", 32'(bus_if.rd_ch_sel), 0);
        check("reset rd_idx", 32'(bus_if.rd_idx), 0);
        check("reset rd_done", 32'(bus_if.rd_done), 0);
        reset = 1'b0;

        // Full mask, period 5: tick in cycle 4, strobes ch0..6, the cycle-9 tick queues a second frame.
        bus_if.div_cfg = 24'd4;
        bus_if.ch_mask = 7'h7F;
        bus_if.enable  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_cap("t1 pre-tick", 1'b0, 0, 1'b0);
        end
        for (int k = 0; k < 7; k++) begin
            step();
            exp_cap("t1 frame", 1'b1, k, k == 6);
        end
        step();
        exp_cap("t1 queued frame", 1'b1, 0, 1'b0);
        bus_if.enable = 1'b0;
        step();
        exp_cap("t1 abort", 1'b0, 0, 1'b0);
        check("t1 abort overrun", 32'(bus_if.overrun), 0);

        // Sparse mask then empty mask.
        bus_if.ch_mask = 7'b0100101;
        bus_if.enable  = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        step(); exp_cap("t2 ch0", 1'b1, 0, 1'b0);
        step(); exp_cap("t2 ch2", 1'b1, 2, 1'b0);
        step(); exp_cap("t2 ch5", 1'b1, 5, 1'b1);
        step(); exp_cap("t2 after frame", 1'b0, 0, 1'b0);
        bus_if.ch_mask = 7'h00;
        for (int i = 0; i < 7; i++) begin
            step();
            exp_cap("t2 empty mask", 1'b0, 0, 1'b0);
        end
        restart();

        // Readout from idle, then an out-of-range request is ignored.
        bus_if.div_cfg = 24'd100;
        bus_if.ch_mask = 7'h7F;
        bus_if.rd_req  = 1'b1;
        bus_if.rd_ch   = 3'd3;
        bus_if.enable  = 1'b1;
        step();
        exp_rd("t3 entry", 1'b0, 0, 0, 1'b0);
        step();
        exp_rd("t3 idx", 1'b1, 3, 0, 1'b0);
        bus_if.rd_req = 1'b0;
        for (int k = 1; k < 10; k++) begin
            step();
            exp_rd("t3 idx", 1'b1, 3, k, k == 9);
        end
        step();
        exp_rd("t3 end", 1'b0, 0, 0, 1'b0);
        bus_if.rd_req = 1'b1;
        bus_if.rd_ch  = 3'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_rd("t3 out of range", 1'b0, 0, 0, 1'b0);
        end
        restart();

        // Period 4, single channel: ticks in cycles 7 and 11 land mid-readout.
        bus_if.div_cfg = 24'd3;
        bus_if.ch_mask = 7'b0000001;
        bus_if.enable  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_cap("t4 pre-tick", 1'b0, 0, 1'b0);
        end
        step(); exp_cap("t4 first frame", 1'b1, 0, 1'b1);
        step(); exp_cap("t4 idle gap", 1'b0, 0, 1'b0);
        bus_if.rd_req = 1'b1;
        bus_if.rd_ch  = 3'd2;
        step();
        exp_rd("t4 idx", 1'b1, 2, 0, 1'b0);
        bus_if.rd_req = 1'b0;
        for (int k = 1; k < 10; k++) begin
            step();
            exp_rd("t4 idx", 1'b1, 2, k, k == 9);
            check("t4 no strobe in readout", 32'(bus_if.cap_wr_en), 0);
            if (k == 5) check("t4 overrun before", 32'(bus_if.overrun), 0);
            if (k == 6) check("t4 overrun after", 32'(bus_if.overrun), 1);
        end
        step();
        exp_cap("t4 pending frame", 1'b1, 0, 1'b1);
        exp_rd("t4 pending frame", 1'b0, 0, 0, 1'b0);
        step(); exp_cap("t4 second pending", 1'b1, 0, 1'b1);
        step(); exp_cap("t4 settle", 1'b0, 0, 1'b0);
        check("t4 overrun sticky", 32'(bus_if.overrun), 1);
        restart();
        check("t4 overrun cleared", 32'(bus_if.overrun), 0);

        // Tick every cycle: overrun on the second pending tick, held until reset.
        bus_if.div_cfg = 24'd0;
        bus_if.ch_mask = 7'h7F;
        bus_if.enable  = 1'b1;
        step();
        exp_cap("t5 entry", 1'b0, 0, 1'b0);
        check("t5 overrun c1", 32'(bus_if.overrun), 0);
        step();
        exp_cap("t5 frame", 1'b1, 0, 1'b0);
        check("t5 overrun c2", 32'(bus_if.overrun), 0);
        for (int k = 1; k < 7; k++) begin
            step();
            exp_cap("t5 frame", 1'b1, k, k == 6);
            check("t5 overrun set", 32'(bus_if.overrun), 1);
        end
        step(); exp_cap("t5 next frame", 1'b1, 0, 1'b0);
        repeat (20) step();
        check("t5 overrun held", 32'(bus_if.overrun), 1);
        reset = 1'b1;
        step();
        exp_cap("t6 reset mid capture", 1'b0, 0, 1'b0);
        check("t6 reset overrun", 32'(bus_if.overrun), 0);
        check("t6 reset cap_ch", 32'(bus_if.cap_ch), 0);
        reset = 1'b0;
        restart();

        // Enable low mid-readout.
        bus_if.div_cfg = 24'd100;
        bus_if.rd_req  = 1'b1;
        bus_if.rd_ch   = 3'd5;
        bus_if.enable  = 1'b1;
        step();
        step();
        exp_rd("t6 readout", 1'b1, 5, 0, 1'b0);
        bus_if.rd_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_rd("t6 readout", 1'b1, 5, k, 1'b0);
        end
        bus_if.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_rd("t6 enable abort", 1'b0, 0, 0, 1'b0);
        end

        // Reset one cycle before the final readout index.
        bus_if.rd_req = 1'b1;
        bus_if.rd_ch  = 3'd6;
        bus_if.enable = 1'b1;
        step();
        step();
        exp_rd("t6 readout2", 1'b1, 6, 0, 1'b0);
        bus_if.rd_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_rd("t6 readout2", 1'b1, 6, k, 1'b0);
        end
        reset = 1'b1;
        step();
        exp_rd("t6 reset abort", 1'b0, 0, 0, 1'b0);
        check("t6 reset rd_idx", 32'(bus_if.rd_idx), 0);
        check("t6 reset rd_ch_sel", 32'(bus_if.rd_ch_sel), 0);
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
